// File: rtl/nl_carry_gen_if.sv
// Handshake bundle between the operand source, nl_carry_gen and the linear XOR network.
// Optional `cout` member exists only when NL_CARRY_OUT_EN is defined.
interface nl_carry_gen_if #(
  parameter int N = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [3*N-6:0]   nl;
  logic             busy;
`ifdef NL_CARRY_OUT_EN
  logic             cout;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, nl, busy, cout
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, nl, busy, cout
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, nl, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, nl, busy
  );
`endif
endinterface

// File: rtl/nl_carry_gen.sv
// Multi-cycle generator of the AND-term vector nl, walking the carry chain BPC positions per cycle.
// Define NL_CARRY_OUT_EN to add the carry out of bit N-1 (bus.cout).
module nl_carry_gen #(
  parameter int N   = 32,
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  nl_carry_gen_if.slave bus
);

  localparam int NLW = 3*N - 5;
  localparam int PW  = $clog2(N) + 1;
`ifdef NL_CARRY_OUT_EN
  localparam int OP_MSB = N - 1;
`else
  localparam int OP_MSB = N - 2;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [OP_MSB:1]   a_q, a_d, b_q, b_d;
  logic              carry_q, carry_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [NLW-1:0]    nl_q, nl_d, nl_run;

  logic [PW-1:0]     pos_end, last_pos;
  logic              last_chunk, chunk_carry;
  logic [N-2:1]      wr_en, c_in, c_out, t_ab, t_ac, t_bc, last_sel;

  // Chunk window: positions pos_q .. pos_end, clipped at N-2.
  assign pos_end    = pos_q + PW'(BPC - 1);
  assign last_chunk = (pos_end >= PW'(N - 2));
  assign last_pos   = last_chunk ? PW'(N - 2) : pos_end;
  assign nl_run[0]  = nl_q[0];

  generate
    for (genvar gi = 1; gi <= N - 2; gi++) begin : g_pos
      // The chunk's first position takes the registered carry; later ones chain combinationally.
      if (gi == 1) begin : g_first
        assign c_in[gi] = carry_q;
      end else begin : g_rest
        assign c_in[gi] = (pos_q == PW'(gi)) ? carry_q : c_out[gi-1];
      end
      assign t_ab[gi]     = a_q[gi] & b_q[gi];
      assign t_ac[gi]     = a_q[gi] & c_in[gi];
      assign t_bc[gi]     = b_q[gi] & c_in[gi];
      assign c_out[gi]    = t_ab[gi] ^ t_ac[gi] ^ t_bc[gi];
      assign wr_en[gi]    = (pos_q <= PW'(gi)) && (PW'(gi) <= pos_end);
      assign last_sel[gi] = (last_pos == PW'(gi));
      assign nl_run[3*gi-2 +: 3] = wr_en[gi] ? {t_bc[gi], t_ac[gi], t_ab[gi]}
                                             : nl_q[3*gi-2 +: 3];
    end
  endgenerate

  assign chunk_carry = |(last_sel & c_out);

`ifdef NL_CARRY_OUT_EN
  logic cout_q, cout_d;
  logic msb_carry;

  assign msb_carry = (a_q[N-1] & b_q[N-1]) | (a_q[N-1] & c_out[N-2]) | (b_q[N-1] & c_out[N-2]);
  assign bus.cout  = cout_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    pos_d   = pos_q;
    nl_d    = nl_q;
`ifdef NL_CARRY_OUT_EN
    cout_d  = cout_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d       = bus.a[OP_MSB:1];
          b_d       = bus.b[OP_MSB:1];
          nl_d[0]   = bus.a[0] & bus.b[0];
          carry_d   = bus.a[0] & bus.b[0];
          pos_d     = PW'(1);
          state_d   = RUN;
        end
      end
      RUN: begin
        nl_d    = nl_run;
        carry_d = chunk_carry;
        pos_d   = pos_q + PW'(BPC);
        if (last_chunk) begin
          state_d = DONE;
`ifdef NL_CARRY_OUT_EN
          cout_d  = msb_carry;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      pos_q   <= '0;
      nl_q    <= '0;
`ifdef NL_CARRY_OUT_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      pos_q   <= pos_d;
      nl_q    <= nl_d;
`ifdef NL_CARRY_OUT_EN
      cout_q  <= cout_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.nl        = nl_q;

endmodule
